// File: rtl/adder_pkg.sv
// Shared types and helpers for the carry-pipelined adder.
// Flag construction lives here so every instance derives cout/ovf the same way.
package adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Result flags carried next to the sum; the sum width is a parameter of the adder.
   typedef struct packed {
      logic cout;
      logic ovf;
   } flags_t;

   function automatic int stages(input int width, input int seg);
      return width / seg;
   endfunction

   // Overflow: carry into the MSB differs from carry out of the MSB.
   function automatic flags_t make_flags(input logic co, input logic c_msb_in);
      flags_t f;
      f.cout = co;
      f.ovf  = co ^ c_msb_in;
      return f;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// SEG-bit combinational slice: a + b + ci, with carry out and carry into the slice MSB.
module adder_slice
   import adder_pkg::*;
#(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] a_i,
   input  logic [SEG-1:0] b_i,
   input  logic           ci_i,
   output logic [SEG-1:0] s_o,
   output logic           co_o,
   output logic           c_msb_in_o
);

   logic [SEG:0] full;

   assign full       = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, ci_i};
   assign s_o        = full[SEG-1:0];
   assign co_o       = full[SEG];
   // The sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out by XOR.
   assign c_msb_in_o = s_o[SEG-1] ^ a_i[SEG-1] ^ b_i[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor: one SEG-bit segment per stage, valid/ready handshake.
// Consumed operand bits are dropped and finished result bits accumulate as a beat moves on.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = stages(WIDTH, SEG);

   if (WIDTH % SEG != 0 || STAGES < 1) begin : g_param_check
      $error("pipelined_adder: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)", WIDTH, SEG);
   end

   // Whole pipeline moves in lock-step; a stalled output freezes every stage.
   logic advance;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO  = gi * SEG;
      localparam int REM = WIDTH - LO;

      logic [REM-1:0]    a_cur;
      logic [REM-1:0]    b_cur;
      logic              c_cur;
      logic              v_cur;
      logic [SEG-1:0]    s;
      logic              co;
      logic              c_msb_in;
      logic [LO+SEG-1:0] res_d;
      logic [LO+SEG-1:0] res_q;
      logic              v_q;

      if (gi == 0) begin : g_head
         assign a_cur = a;
         assign b_cur = (sub == OP_SUB) ? ~b : b;
         assign c_cur = (sub == OP_SUB) ? 1'b1 : cin;
         assign v_cur = in_valid;
         assign res_d = s;
      end else begin : g_body
         assign a_cur = g_stage[gi-1].g_fwd.a_q;
         assign b_cur = g_stage[gi-1].g_fwd.b_q;
         assign c_cur = g_stage[gi-1].g_fwd.c_q;
         assign v_cur = g_stage[gi-1].v_q;
         assign res_d = {s, g_stage[gi-1].res_q};
      end

      adder_slice #(
         .SEG (SEG)
      ) u_slice (
         .a_i        (a_cur[SEG-1:0]),
         .b_i        (b_cur[SEG-1:0]),
         .ci_i       (c_cur),
         .s_o        (s),
         .co_o       (co),
         .c_msb_in_o (c_msb_in)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            res_q <= '0;
         end else if (advance) begin
            v_q   <= v_cur;
            res_q <= res_d;
         end
      end

      if (gi < STAGES - 1) begin : g_fwd
         logic [REM-SEG-1:0] a_q;
         logic [REM-SEG-1:0] b_q;
         logic               c_q;
         logic               unused_c_msb_in;

         // Only the final segment's MSB carry matters for overflow.
         assign unused_c_msb_in = c_msb_in;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
               c_q <= 1'b0;
            end else if (advance) begin
               a_q <= a_cur[REM-1:SEG];
               b_q <= b_cur[REM-1:SEG];
               c_q <= co;
            end
         end
      end else begin : g_tail
         flags_t flags_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               flags_q <= '0;
            end else if (advance) begin
               flags_q <= make_flags(co, c_msb_in);
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign sum       = g_stage[STAGES-1].res_q;
   assign cout      = g_stage[STAGES-1].g_tail.flags_q.cout;
   assign ovf       = g_stage[STAGES-1].g_tail.flags_q.ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench: a 4-stage (16/4) and a single-stage (16/16) adder share one input stream,
// each checked against its own queue of results computed with plain arithmetic.
module tb_pipelined_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        cin;
   logic        sub;
   logic        out_ready;
   logic [15:0] a;
   logic [15:0] b;

   logic        in_ready1, out_valid1, cout1, ovf1;
   logic [15:0] sum1;
   logic        in_ready2, out_valid2, cout2, ovf2;
   logic [15:0] sum2;

   int checks   = 0;
   int failures = 0;
   int del1     = 0;
   int del2     = 0;
   int sent;
   int cyc;
   logic d1, d2;
   logic [17:0] q1[$];
   logic [17:0] q2[$];
   logic [15:0] ta[8];
   logic [15:0] tb[8];
   logic        tc[8];
   logic        ts[8];

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(16), .SEG(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .sum       (sum1),
      .cout      (cout1),
      .ovf       (ovf1)
   );

   pipelined_adder #(.WIDTH(16), .SEG(16)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid2),
      .out_ready (out_ready),
      .sum       (sum2),
      .cout      (cout2),
      .ovf       (ovf2)
   );

   // Reference result {cout, ovf, sum} from integer arithmetic.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic s);
      int unsigned r;
      logic [15:0] res;
      logic        co;
      logic        ov;
      if (!s) begin
         r   = 32'(x) + 32'(y) + 32'(ci);
         res = r[15:0];
         co  = r[16];
         ov  = (x[15] == y[15]) && (res[15] != x[15]);
      end else begin
         res = x - y;
         co  = (x >= y);
         ov  = (x[15] != y[15]) && (res[15] != x[15]);
      end
      return {co, ov, res};
   endfunction

   function automatic logic [15:0] pick();
      logic [15:0] v;
      case ($urandom_range(0, 7))
         0:       v = 16'h0000;
         1:       v = 16'hFFFF;
         2:       v = 16'h7FFF;
         3:       v = 16'h8000;
         default: v = 16'($urandom);
      endcase
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at the falling edge, then score both outputs before the rising edge.
   task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic isub, input logic ordy,
                       output logic acc1, output logic acc2);
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = isub;
      out_ready = ordy;
      #1;
      if (out_valid1) begin
         chk("dut4_result_pending", 32'(q1.size() != 0), 1);
         if (q1.size() != 0) begin
            chk("dut4_result", {14'd0, cout1, ovf1, sum1}, {14'd0, q1[0]});
            if (ordy) begin
               void'(q1.pop_front());
               del1++;
            end
         end
      end
      if (out_valid2) begin
         chk("dut1_result_pending", 32'(q2.size() != 0), 1);
         if (q2.size() != 0) begin
            chk("dut1_result", {14'd0, cout2, ovf2, sum2}, {14'd0, q2[0]});
            if (ordy) begin
               void'(q2.pop_front());
               del2++;
            end
         end
      end
      acc1 = iv && in_ready1;
      acc2 = iv && in_ready2;
      if (acc1) q1.push_back(model(ia, ib, ic, isub));
      if (acc2) q2.push_back(model(ia, ib, ic, isub));
   endtask

   // Single isolated beat with a hard-coded expected result and latency.
   task automatic run_beat(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                           input logic isub, input logic [15:0] es, input logic ec,
                           input logic eo);
      int n;
      int lat1;
      int lat2;
      @(negedge clk);
      in_valid  = 1'b1;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = isub;
      out_ready = 1'b1;
      #1;
      chk("beat_in_ready4", 32'(in_ready1), 1);
      chk("beat_in_ready1", 32'(in_ready2), 1);
      n    = 0;
      lat1 = 0;
      lat2 = 0;
      while ((lat1 == 0 || lat2 == 0) && n < 20) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         n++;
         if (out_valid1 && lat1 == 0) begin
            lat1 = n;
            chk("beat_sum4", 32'(sum1), 32'(es));
            chk("beat_cout4", 32'(cout1), 32'(ec));
            chk("beat_ovf4", 32'(ovf1), 32'(eo));
         end
         if (out_valid2 && lat2 == 0) begin
            lat2 = n;
            chk("beat_sum1", 32'(sum2), 32'(es));
            chk("beat_cout1", 32'(cout2), 32'(ec));
            chk("beat_ovf1", 32'(ovf2), 32'(eo));
         end
      end
      chk("beat_latency4", 32'(lat1), 4);
      chk("beat_latency1", 32'(lat2), 1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid4", 32'(out_valid1), 0);
      chk("rst_sum4", 32'(sum1), 0);
      chk("rst_cout4", 32'(cout1), 0);
      chk("rst_ovf4", 32'(ovf1), 0);
      chk("rst_out_valid1", 32'(out_valid2), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rel_in_ready4", 32'(in_ready1), 1);
      chk("rel_in_ready1", 32'(in_ready2), 1);

      run_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_beat(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_beat(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_beat(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      run_beat(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

      // Eight back-to-back beats with the consumer stalled on cycles 5..7.
      for (int i = 0; i < 8; i++) begin
         ta[i] = pick();
         tb[i] = pick();
         tc[i] = 1'($urandom);
         ts[i] = 1'($urandom);
      end
      sent = 0;
      cyc  = 0;
      del1 = 0;
      del2 = 0;
      while ((del1 < 8 || del2 < 8) && cyc < 40) begin
         step(sent < 8, ta[sent % 8], tb[sent % 8], tc[sent % 8], ts[sent % 8],
              !(cyc >= 5 && cyc <= 7), d1, d2);
         chk("b2b_in_ready4", 32'(in_ready1), 32'(!(cyc >= 5 && cyc <= 7)));
         chk("b2b_in_ready1", 32'(in_ready2), 32'(!(cyc >= 5 && cyc <= 7)));
         if (d1) sent++;
         cyc++;
      end
      chk("b2b_delivered4", 32'(del1), 8);
      chk("b2b_delivered1", 32'(del2), 8);

      // Reset with beats in flight and the output stalled.
      repeat (3) step(1'b1, pick(), pick(), 1'($urandom), 1'($urandom), 1'b0, d1, d2);
      repeat (2) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, d1, d2);
      chk("mid_valid_before_rst4", 32'(out_valid1), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid4", 32'(out_valid1), 0);
      chk("mid_rst_out_valid1", 32'(out_valid2), 0);
      chk("mid_rst_sum4", 32'(sum1), 0);
      q1.delete();
      q2.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, pick(), pick(), 1'b0, 1'b0, 1'b1, d1, d2);
         chk("post_rst_idle4", 32'(out_valid1), 0);
         chk("post_rst_idle1", 32'(out_valid2), 0);
      end
      chk("post_rst_in_ready4", 32'(in_ready1), 1);
      run_beat(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

      // Random traffic with random source gaps and consumer stalls.
      for (int i = 0; i < 10000; i++) begin
         step($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3) != 0, d1, d2);
      end
      for (int i = 0; i < 40 && (q1.size() != 0 || q2.size() != 0); i++) begin
         step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, d1, d2);
      end
      chk("drain_empty4", 32'(q1.size()), 0);
      chk("drain_empty1", 32'(q2.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
